// File: rtl/sys_mem_ctrl_if.sv
// Cache-controller to memory-controller bus: strobe-started single-word accesses
// completed by a one-cycle SysReady pulse; no backpressure beyond Busy/Overrun.
interface sys_mem_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              SysStrobe;
  logic              SysRW;
  logic [ADDR_W-1:0] SysAddr;
  logic [DATA_W-1:0] SysDataIn;
  logic              SysDataOE;
  logic [DATA_W-1:0] SysDataOut;
  logic              SysReady;
  logic              Busy;
  logic              Overrun;

  modport master (
    output SysStrobe, SysRW, SysAddr, SysDataIn, SysDataOE,
    input  SysDataOut, SysReady, Busy, Overrun
  );

  modport slave (
    input  SysStrobe, SysRW, SysAddr, SysDataIn, SysDataOE,
    output SysDataOut, SysReady, Busy, Overrun
  );
endinterface

// File: rtl/sys_mem_ctrl.sv
// Single-port word memory behind a strobe-edge bus; SysReady pulses WAITSTATE cycles
// after the accepted edge. Edges arriving while busy are dropped and flagged in Overrun.
module sys_mem_ctrl #(
  parameter int WAITSTATE = 2,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32
) (
  input logic          Clk,
  input logic          Reset,
  sys_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAITSTATE - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              strobe_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] dout_q;
  logic              rdy_q;
  logic              busy_q;
  logic              ovr_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic strobe_edge;
  logic mem_we;

  always_comb begin
    strobe_edge = bus.SysStrobe & ~strobe_q;
    mem_we      = (state_q == WAIT) && (cnt_q == 4'd0) && rw_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      strobe_q <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      dout_q   <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      strobe_q <= bus.SysStrobe;
      rdy_q    <= 1'b0;
      if (strobe_edge && (state_q != IDLE)) ovr_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (strobe_edge) begin
            rw_q    <= bus.SysRW;
            addr_q  <= bus.SysAddr;
            data_q  <= bus.SysDataOE ? bus.SysDataIn : '0;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Read data lands together with the ready pulse; writes leave dout_q alone.
            if (!rw_q) dout_q <= mem[addr_q];
            rdy_q   <= 1'b1;
            state_q <= XFER;
          end
        end
        XFER: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Contents deliberately not reset; an aborted access never reaches the write enable.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[addr_q] <= data_q;
  end

  assign bus.SysDataOut = dout_q;
  assign bus.SysReady   = rdy_q;
  assign bus.Busy       = busy_q;
  assign bus.Overrun    = ovr_q;

endmodule

// File: tb/tb_sys_mem_ctrl.sv
// Scoreboarded bench for sys_mem_ctrl: one instance at WAITSTATE=2, one at WAITSTATE=1.
module tb_sys_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2_n;
  logic rst1_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sys_mem_ctrl_if b2 ();
  sys_mem_ctrl_if b1 ();

  sys_mem_ctrl #(.WAITSTATE(2), .ADDR_W(8), .DATA_W(32)) u2 (.Clk(clk), .Reset(rst2_n), .bus(b2));
  sys_mem_ctrl #(.WAITSTATE(1), .ADDR_W(8), .DATA_W(32)) u1 (.Clk(clk), .Reset(rst1_n), .bus(b1));

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin : mon2
    exp_t e;
    if (b2.SysReady === 1'b1) begin
      if (q2.size() == 0) begin
        n_tot++;
        $display("FAIL rdy2_unexpected: SysReady at cycle %0d with no access pending", cyc);
      end else begin
        e = q2.pop_front();
        chk("rdy2_cycle", cyc, e.cyc);
        if (e.rd) chk("rdy2_data", b2.SysDataOut, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (b1.SysReady === 1'b1) begin
      if (q1.size() == 0) begin
        n_tot++;
        $display("FAIL rdy1_unexpected: SysReady at cycle %0d with no access pending", cyc);
      end else begin
        e = q1.pop_front();
        chk("rdy1_cycle", cyc, e.cyc);
        if (e.rd) chk("rdy1_data", b1.SysDataOut, e.data);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv2(input bit s, input bit rw, input logic [7:0] a, input logic [31:0] d);
    b2.SysStrobe = s;
    b2.SysRW     = rw;
    b2.SysAddr   = a;
    b2.SysDataIn = d;
    b2.SysDataOE = rw;
  endtask

  // One-cycle strobe; RW/addr are scrambled right after acceptance.
  task automatic acc2(input bit rw, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd);
    int k;
    tick;
    drv2(1'b1, rw, a, d);
    k = cyc + 1;
    q2.push_back('{k + 2, !rw, exp_rd});
    tick;
    drv2(1'b0, !rw, a + 8'd1, 32'h0);
    repeat (3) tick;
  endtask

  task automatic busy1(output int nb);
    nb = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nb += int'(b1.Busy);
      if (i == 1) b1.SysStrobe = 1'b0;
    end
  endtask

  initial begin
    int k;
    int nb;
    rst2_n = 1'b0;
    rst1_n = 1'b0;
    drv2(1'b0, 1'b0, 8'h00, 32'h0);
    // dut1 strobe already high across reset release: must be taken as an edge.
    b1.SysStrobe = 1'b1;
    b1.SysRW     = 1'b1;
    b1.SysAddr   = 8'h00;
    b1.SysDataIn = 32'h0000_0001;
    b1.SysDataOE = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst2_ready",   b2.SysReady,   32'h0);
    chk("rst2_busy",    b2.Busy,       32'h0);
    chk("rst2_overrun", b2.Overrun,    32'h0);
    chk("rst2_dout",    b2.SysDataOut, 32'h0);
    chk("rst1_ready",   b1.SysReady,   32'h0);
    chk("rst1_busy",    b1.Busy,       32'h0);

    tick;
    rst1_n = 1'b1;
    rst2_n = 1'b1;
    k = cyc + 1;
    q1.push_back('{k + 1, 1'b0, 32'h0});
    busy1(nb);
    chk("busy1_write", nb, 32'd2);

    tick;
    b1.SysStrobe = 1'b1;
    b1.SysRW     = 1'b0;
    b1.SysAddr   = 8'h00;
    b1.SysDataIn = 32'h0;
    b1.SysDataOE = 1'b0;
    k = cyc + 1;
    q1.push_back('{k + 1, 1'b1, 32'h0000_0001});
    busy1(nb);
    chk("busy1_read", nb, 32'd2);

    acc2(1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0);
    acc2(1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF);

    // Strobe held for six edges: one access only, no overrun.
    tick;
    drv2(1'b1, 1'b1, 8'h30, 32'h0000_0055);
    k = cyc + 1;
    q2.push_back('{k + 2, 1'b0, 32'h0});
    repeat (6) tick;
    b2.SysStrobe = 1'b0;
    repeat (2) tick;
    chk("ovr_held_strobe", b2.Overrun, 32'h0);

    // Drop and re-raise during WAIT: second edge ignored, overrun set.
    tick;
    drv2(1'b1, 1'b0, 8'h10, 32'h0);
    k = cyc + 1;
    q2.push_back('{k + 2, 1'b1, 32'hDEAD_BEEF});
    tick;
    b2.SysStrobe = 1'b0;
    tick;
    b2.SysStrobe = 1'b1;
    b2.SysAddr   = 8'h30;
    tick;
    b2.SysStrobe = 1'b0;
    repeat (3) tick;
    chk("ovr_reraise", b2.Overrun, 32'h1);
    chk("dout_after_reraise", b2.SysDataOut, 32'hDEAD_BEEF);

    // Reset in WAIT of a write must abort it.
    acc2(1'b1, 8'h20, 32'hAAAA_AAAA, 32'h0);
    tick;
    drv2(1'b1, 1'b1, 8'h20, 32'h1234_5678);
    tick;
    rst2_n = 1'b0;
    b2.SysStrobe = 1'b0;
    @(negedge clk);
    chk("abort_ready",   b2.SysReady,   32'h0);
    chk("abort_busy",    b2.Busy,       32'h0);
    chk("abort_overrun", b2.Overrun,    32'h0);
    chk("abort_dout",    b2.SysDataOut, 32'h0);
    tick;
    rst2_n = 1'b1;
    repeat (4) tick;
    acc2(1'b0, 8'h20, 32'h0, 32'hAAAA_AAAA);

    // Top address and wrap-around neighbour stay distinct.
    acc2(1'b1, 8'h00, 32'h0BAD_C0DE, 32'h0);
    acc2(1'b1, 8'hFF, 32'hCAFE_F00D, 32'h0);
    acc2(1'b0, 8'hFF, 32'h0, 32'hCAFE_F00D);
    acc2(1'b0, 8'h00, 32'h0, 32'h0BAD_C0DE);
    acc2(1'b1, 8'h40, 32'h0000_1234, 32'h0);
    chk("dout_hold_after_write", b2.SysDataOut, 32'h0BAD_C0DE);

    repeat (5) tick;
    chk("q2_drained", q2.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/sys_mem_ctrl.md
SYS_MEM_CTRL -- requirements
Module: sys_mem_ctrl

Interface
REQ-001 Parameter WAITSTATE, default 2: cycles from accepted strobe to SysReady. Legal range is 1..15.
REQ-002 Parameter ADDR_W, default 8: address width. Memory depth is 2**ADDR_W words.
REQ-003 Parameter DATA_W, default 32: data word width.
REQ-004 Clk  input  1  system clock; all state changes on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low (0 = reset).
REQ-006 SysStrobe  input  1  access request from the cache controller.
REQ-007 SysRW  input  1  0 = read, 1 = write.
REQ-008 SysAddr  input  ADDR_W  word address.
REQ-009 SysDataIn  input  DATA_W  write data, valid while SysDataOE = 1.
REQ-010 SysDataOE  input  1  controller is driving write data.
REQ-011 SysDataOut  output  DATA_W  read data (registered).
REQ-012 SysReady  output  1  one-cycle completion pulse.
REQ-013 Busy  output  1  access in progress (state != IDLE).
REQ-014 Overrun  output  1  sticky flag: new request arrived while busy.

Function
REQ-015 The block SHALL implement the states IDLE, WAIT and XFER, with a 4-bit down-counter Cnt.
REQ-016 Acceptance: only a strobe rising edge (SysStrobe = 1 with previous-cycle SysStrobe = 0) SHALL start an access. A strobe held high SHALL NOT start a second access.
REQ-017 On an edge accepted in IDLE, the block SHALL latch SysAddr, SysRW and SysDataIn (SysDataIn only if SysDataOE = 1; otherwise the latched data SHALL be 0), load Cnt = WAITSTATE-1, and enter WAIT.
REQ-018 In WAIT: if Cnt != 0, Cnt SHALL decrement; if Cnt == 0, the block SHALL enter XFER.
REQ-019 On the WAIT->XFER edge: a read SHALL load SysDataOut = mem[latched addr]; a write SHALL store mem[latched addr] = latched data.
REQ-020 In XFER, SysReady SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-021 Latency: a strobe edge sampled at rising edge k SHALL produce SysReady high in the cycle following edge k+WAITSTATE.
REQ-022 SysDataOut SHALL hold its last read value until the next read completes; writes SHALL NOT alter it.
REQ-023 Busy SHALL be 1 in WAIT and XFER, and 0 in IDLE.
REQ-024 A strobe rising edge in WAIT or XFER SHALL be ignored and SHALL set Overrun = 1. Overrun is cleared only by reset.
REQ-025 Address arithmetic is modulo 2**ADDR_W; no out-of-range access exists.
REQ-026 Simultaneous write and read to the same address is impossible (one access at a time). A read following a write to the same address SHALL return the written data.
REQ-027 SysRW and SysAddr changes after acceptance SHALL have no effect on the access in progress.
REQ-028 Memory contents are not reset; reading a never-written address returns undefined data.

Reset
REQ-029 Reset = 0 SHALL immediately force the state to IDLE, Cnt = 0, SysReady = 0, Busy = 0, Overrun = 0, SysDataOut = 0, and the strobe history register = 0.
REQ-030 Reset asserted during WAIT SHALL abort the access with no memory write and no SysReady pulse.
REQ-031 After reset release, a strobe already high at the first edge counts as a rising edge and SHALL be accepted.

Verification
REQ-032 Write then read, WAITSTATE = 2: write 0xDEADBEEF to address 0x10, then read 0x10. Required: each SysReady occurs 2 cycles after its strobe edge, and SysDataOut = 0xDEADBEEF.
REQ-033 WAITSTATE = 1: read of address 0x00 after writing 0x00000001. Required: SysReady 1 cycle after the edge, Busy high for exactly 2 cycles.
REQ-034 SysStrobe held high for 6 cycles with WAITSTATE = 2. Required: exactly one SysReady, and Overrun stays 0.
REQ-035 Strobe dropped and re-raised during WAIT. Required: Overrun = 1, the second request is ignored, and the first access completes normally.
REQ-036 Reset pulsed in WAIT of a write of 0x12345678 to address 0x20, where 0x20 previously held 0xAAAAAAAA. Required: no SysReady, all outputs 0, and a later read of 0x20 returns 0xAAAAAAAA.
REQ-037 Write to address 0xFF, then read 0xFF and 0x00. Required: data is correct at 0xFF with no aliasing into 0x00.
